// File: rtl/i2c_wb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_wb_bus_arbiter
// Shares one wbi2cmaster Wishbone slave between SERV's mem and ext buses.
// A request is latched in IDLE, issued as a pipelined Wishbone cycle (stall
// honoured), and the captured response is returned to the granted requester
// as a one-cycle ack. A watchdog aborts cycles that the slave never acks,
// returning all-ones data and pulsing o_timeout.
//
// Ports
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_mem_* / o_mem_*            mem requester (adr, dat, sel, we, stb / rdt, ack)
//   i_ext_* / o_ext_*            ext requester (same set)
//   o_wb_cyc/stb/we/addr/data/sel  downstream Wishbone master side
//   i_wb_stall/ack/data          downstream slave responses
//   o_timeout                    one-cycle pulse when the watchdog aborts
// ---------------------------------------------------------------------------
module i2c_wb_bus_arbiter #(
  parameter int ADDR_W      = 7,
  parameter int TIMEOUT_W   = 16,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [31:0]       i_mem_adr,
  input  logic [31:0]       i_mem_dat,
  input  logic [3:0]        i_mem_sel,
  input  logic              i_mem_we,
  input  logic              i_mem_stb,
  output logic [31:0]       o_mem_rdt,
  output logic              o_mem_ack,
  input  logic [31:0]       i_ext_adr,
  input  logic [31:0]       i_ext_dat,
  input  logic [3:0]        i_ext_sel,
  input  logic              i_ext_we,
  input  logic              i_ext_stb,
  output logic [31:0]       o_ext_rdt,
  output logic              o_ext_ack,
  output logic              o_wb_cyc,
  output logic              o_wb_stb,
  output logic              o_wb_we,
  output logic [ADDR_W-1:0] o_wb_addr,
  output logic [31:0]       o_wb_data,
  output logic [3:0]        o_wb_sel,
  input  logic              i_wb_stall,
  input  logic              i_wb_ack,
  input  logic [31:0]       i_wb_data,
  output logic              o_timeout
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_RESP = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic GNT_MEM = 1'b0;
  localparam logic GNT_EXT = 1'b1;
  localparam logic [TIMEOUT_W-1:0] WD_LIMIT = TIMEOUT_W'(TIMEOUT_CYC - 1);
  localparam logic [TIMEOUT_W-1:0] WD_ONE   = TIMEOUT_W'(1);

  state_t              state_q, state_d;
  logic                grant_q, grant_d;
  logic                last_q, last_d;
  logic [ADDR_W-1:0]   adr_q, adr_d;
  logic [31:0]         dat_q, dat_d;
  logic [3:0]          sel_q, sel_d;
  logic                we_q, we_d;
  logic [TIMEOUT_W-1:0] wd_q, wd_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                timeout_d;
  logic                pick_ext;

  logic                cyc_q, stb_q, mem_ack_q, ext_ack_q, timeout_q;
  logic [31:0]         mem_rdt_q, ext_rdt_q;

  // Only the word-address bits reach the slave; the rest are intentionally dropped.
  logic unused_adr_bits;
  assign unused_adr_bits = ^{i_mem_adr[31:ADDR_W+2], i_mem_adr[1:0],
                             i_ext_adr[31:ADDR_W+2], i_ext_adr[1:0]};

  // Next-state, arbitration, latching and watchdog logic.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    sel_d     = sel_q;
    we_d      = we_q;
    wd_d      = wd_q;
    rdata_d   = rdata_q;
    timeout_d = 1'b0;
    // On a tie the requester that was not served last wins.
    pick_ext  = i_ext_stb && (!i_mem_stb || (last_q == GNT_MEM));
    case (state_q)
      S_IDLE: begin
        if (i_mem_stb || i_ext_stb) begin
          grant_d = pick_ext ? GNT_EXT : GNT_MEM;
          last_d  = pick_ext ? GNT_EXT : GNT_MEM;
          adr_d   = pick_ext ? i_ext_adr[ADDR_W+1:2] : i_mem_adr[ADDR_W+1:2];
          dat_d   = pick_ext ? i_ext_dat : i_mem_dat;
          sel_d   = pick_ext ? i_ext_sel : i_mem_sel;
          we_d    = pick_ext ? i_ext_we  : i_mem_we;
          wd_d    = '0;
          state_d = S_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        // An ack is only meaningful once the strobe has been accepted.
        if (!i_wb_stall && i_wb_ack) begin
          rdata_d = i_wb_data;
          state_d = S_RESP;
        end else if (wd_q == WD_LIMIT) begin
          rdata_d   = 32'hFFFF_FFFF;
          timeout_d = 1'b1;
          state_d   = S_RESP;
        end else if (!i_wb_stall) begin
          wd_d    = wd_q + WD_ONE;
          state_d = S_WAIT;
        end else begin
          wd_d    = wd_q + WD_ONE;
        end
      end
      S_WAIT: begin
        if (i_wb_ack) begin
          rdata_d = i_wb_data;
          state_d = S_RESP;
        end else if (wd_q == WD_LIMIT) begin
          rdata_d   = 32'hFFFF_FFFF;
          timeout_d = 1'b1;
          state_d   = S_RESP;
        end else begin
          wd_d = wd_q + WD_ONE;
        end
      end
      S_RESP:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, latches and registered outputs decoded from the next state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      grant_q   <= GNT_MEM;
      last_q    <= GNT_EXT;
      adr_q     <= '0;
      dat_q     <= 32'h0000_0000;
      sel_q     <= 4'h0;
      we_q      <= 1'b0;
      wd_q      <= '0;
      rdata_q   <= 32'h0000_0000;
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      mem_ack_q <= 1'b0;
      ext_ack_q <= 1'b0;
      timeout_q <= 1'b0;
      mem_rdt_q <= 32'h0000_0000;
      ext_rdt_q <= 32'h0000_0000;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      sel_q     <= sel_d;
      we_q      <= we_d;
      wd_q      <= wd_d;
      rdata_q   <= rdata_d;
      cyc_q     <= (state_d == S_REQ) || (state_d == S_WAIT);
      stb_q     <= (state_d == S_REQ);
      mem_ack_q <= (state_d == S_RESP) && (grant_d == GNT_MEM);
      ext_ack_q <= (state_d == S_RESP) && (grant_d == GNT_EXT);
      timeout_q <= timeout_d;
      if ((state_d == S_RESP) && (grant_d == GNT_MEM)) begin
        mem_rdt_q <= rdata_d;
      end
      if ((state_d == S_RESP) && (grant_d == GNT_EXT)) begin
        ext_rdt_q <= rdata_d;
      end
    end
  end

  assign o_wb_cyc  = cyc_q;
  assign o_wb_stb  = stb_q;
  assign o_wb_we   = we_q;
  assign o_wb_addr = adr_q;
  assign o_wb_data = dat_q;
  assign o_wb_sel  = sel_q;
  assign o_mem_ack = mem_ack_q;
  assign o_ext_ack = ext_ack_q;
  assign o_mem_rdt = mem_rdt_q;
  assign o_ext_rdt = ext_rdt_q;
  assign o_timeout = timeout_q;

endmodule
